// File: rtl/test_pattern_gen_if.sv
// Pixel-timing in, colour out, grouped for the pattern generator.
// Latency: not applicable (signal bundle only).
// Backpressure: none; the raster source is free-running.
interface test_pattern_gen_if;
  logic [11:0] hcount;       // current pixel column
  logic [11:0] vcount;       // current line
  logic        de;           // high on active pixels
  logic [1:0]  mode_req;     // requested pattern
  logic [23:0] rgb;          // registered pixel colour {R,G,B}
  logic        de_out;       // de delayed to align with rgb
  logic [1:0]  mode_active;  // pattern currently being drawn

  // Raster source / sink side
  modport master (
    output hcount, vcount, de, mode_req,
    input  rgb, de_out, mode_active
  );

  // Pattern generator side
  modport slave (
    input  hcount, vcount, de, mode_req,
    output rgb, de_out, mode_active
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: border+fill, colour bars, checkerboard, bouncing box.
// Latency: one clk from hcount/vcount/de to rgb/de_out.
// Backpressure: none; one pixel is produced every clk the raster supplies one.
module test_pattern_gen #(
  parameter int          H_ACTIVE   = 1280,
  parameter int          V_ACTIVE   = 720,
  parameter int          BORDER     = 8,
  parameter logic [23:0] FILL_RGB   = 24'h0000FF,
  parameter logic [23:0] BOX_RGB    = 24'hFFFF00,
  parameter int          BOX_SIZE   = 64,
  parameter int          BOX_STEP   = 4,
  parameter int          CHECK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  test_pattern_gen_if.slave  bus
);

  // Elaboration-time geometry, widened to 13 bits where sums could carry.
  localparam logic [11:0] H_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] BRD_LO  = 12'(BORDER);
  localparam logic [11:0] BRD_HR  = 12'(H_ACTIVE - BORDER);
  localparam logic [11:0] BRD_VB  = 12'(V_ACTIVE - BORDER);
  localparam logic [12:0] X_LIM   = 13'(H_ACTIVE - BOX_SIZE);
  localparam logic [12:0] Y_LIM   = 13'(V_ACTIVE - BOX_SIZE);
  localparam logic [12:0] STEP13  = 13'(BOX_STEP);
  localparam logic [12:0] SIZE13  = 13'(BOX_SIZE);
  localparam int          BAR_W   = H_ACTIVE / 8;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BLACK   = 24'h000000;

  logic        frame_end;
  logic        on_border;
  logic        in_box;
  logic        checker_bit;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] pix_rgb;

  logic [11:0] box_x, box_y;
  logic        dir_x, dir_y;
  logic [11:0] box_x_nxt, box_y_nxt;
  logic        dir_x_nxt, dir_y_nxt;

  // One-axis bounce step: clamp to the travel limit and reverse in the same
  // update so the box never overshoots. Returns {dir, pos}.
  function automatic logic [12:0] axis_next(
    input logic [11:0] pos,
    input logic        dir,
    input logic [12:0] lim
  );
    logic [12:0] res;
    if (dir) begin
      if ({1'b0, pos} + STEP13 >= lim) begin
        res = {1'b0, lim[11:0]};
      end else begin
        res = {1'b1, pos + STEP13[11:0]};
      end
    end else begin
      if ({1'b0, pos} <= STEP13) begin
        res = {1'b1, 12'd0};
      end else begin
        res = {1'b0, pos - STEP13[11:0]};
      end
    end
    return res;
  endfunction

  // Last active pixel of the frame: the only point where mode and box advance.
  always_comb begin
    frame_end = bus.de && (bus.hcount == H_LAST) && (bus.vcount == V_LAST);
  end

  // Geometric classification of the current pixel.
  always_comb begin
    on_border   = (bus.hcount < BRD_LO) || (bus.hcount >= BRD_HR) ||
                  (bus.vcount < BRD_LO) || (bus.vcount >= BRD_VB);
    in_box      = ({1'b0, bus.hcount} >= {1'b0, box_x}) &&
                  ({1'b0, bus.hcount} <  {1'b0, box_x} + SIZE13) &&
                  ({1'b0, bus.vcount} >= {1'b0, box_y}) &&
                  ({1'b0, bus.vcount} <  {1'b0, box_y} + SIZE13);
    checker_bit = bus.hcount[CHECK_LOG2] ^ bus.vcount[CHECK_LOG2];
  end

  // Bar index from seven constant thresholds; the last threshold passed wins,
  // so no divider is needed and remainder columns fall into bar 7.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bus.hcount >= 12'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end

  // Bar colour lookup.
  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Pattern select by the latched mode; box beats border beats fill in mode 3.
  always_comb begin
    case (bus.mode_active)
      2'd0:    pix_rgb = on_border ? WHITE : FILL_RGB;
      2'd1:    pix_rgb = bar_rgb;
      2'd2:    pix_rgb = checker_bit ? WHITE : BLACK;
      default: pix_rgb = in_box ? BOX_RGB : (on_border ? WHITE : FILL_RGB);
    endcase
  end

  // Next box position for both axes.
  always_comb begin
    {dir_x_nxt, box_x_nxt} = axis_next(box_x, dir_x, X_LIM);
    {dir_y_nxt, box_y_nxt} = axis_next(box_y, dir_y, Y_LIM);
  end

  // Output register: blank outside the active area, de delayed alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rgb    <= BLACK;
      bus.de_out <= 1'b0;
    end else begin
      bus.rgb    <= bus.de ? pix_rgb : BLACK;
      bus.de_out <= bus.de;
    end
  end

  // Mode latches only at frame end so a frame is never drawn in two modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mode_active <= 2'd0;
    end else if (frame_end) begin
      bus.mode_active <= bus.mode_req;
    end
  end

  // Box motion advances once per frame in every mode, even when not shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      box_x <= 12'd0;
      box_y <= 12'd0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_end) begin
      box_x <= box_x_nxt;
      box_y <= box_y_nxt;
      dir_x <= dir_x_nxt;
      dir_y <= dir_y_nxt;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen at default parameters.
// Latency: each step drives one pixel and checks the registered result one clk later.
// Backpressure: none; frame ends are injected directly instead of scanning whole frames.
module tb_test_pattern_gen;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  // Reference state: latched mode and number of frame ends since reset.
  int   mode_m = 0;
  int   nf     = 0;

  test_pattern_gen_if bus ();

  test_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Box travel as a triangle wave of frame count. BOX_STEP (4) divides both
  // spans (1216, 656), so clamping lands exactly on the turning points.
  function automatic int tri_pos(input int n, input int span);
    int p, k, pos;
    p   = (2 * span) / 4;
    k   = n % p;
    pos = k * 4;
    return (pos <= span) ? pos : (2 * span - pos);
  endfunction

  function automatic int tri_dir(input int n, input int span);
    int p;
    p = (2 * span) / 4;
    return ((n % p) < (p / 2)) ? 1 : 0;
  endfunction

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected colour of an active pixel from the pattern rules.
  function automatic logic [23:0] ref_pix(input int mode, input int h, input int v, input int n);
    bit brd;
    int bx, by;
    brd = (h < 8) || (h >= 1272) || (v < 8) || (v >= 712);
    bx  = tri_pos(n, 1216);
    by  = tri_pos(n, 656);
    case (mode)
      0: return brd ? 24'hFFFFFF : 24'h0000FF;
      1: return bar_colour(h / 160);
      2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: begin
        if (h >= bx && h < bx + 64 && v >= by && v < by + 64) return 24'hFFFF00;
        return brd ? 24'hFFFFFF : 24'h0000FF;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, clock it, update the reference, check the outputs.
  task automatic step(input int h, input int v, input bit d, input bit r, input int m);
    logic [23:0] e;
    bit          fe;
    bus.hcount   = 12'(h);
    bus.vcount   = 12'(v);
    bus.de       = d;
    bus.mode_req = 2'(m);
    rst          = r;
    e  = d ? ref_pix(mode_m, h, v, nf) : 24'h0;
    fe = d && (h == 1279) && (v == 719);
    @(posedge clk);
    #1;
    if (r) begin
      mode_m = 0;
      nf     = 0;
      e      = 24'h0;
    end else if (fe) begin
      mode_m = m;
      nf++;
    end
    check("rgb",         32'(bus.rgb),         32'(e));
    check("de_out",      32'(bus.de_out),      32'(r ? 1'b0 : d));
    check("mode_active", 32'(bus.mode_active), 32'(mode_m));
  endtask

  task automatic check_box();
    check("box_x", 32'(dut.box_x), 32'(tri_pos(nf, 1216)));
    check("box_y", 32'(dut.box_y), 32'(tri_pos(nf, 656)));
    check("dir_x", 32'(dut.dir_x), 32'(tri_dir(nf, 1216)));
    check("dir_y", 32'(dut.dir_y), 32'(tri_dir(nf, 656)));
  endtask

  task automatic frame_end(input int m);
    step(1279, 719, 1'b1, 1'b0, m);
  endtask

  task automatic random_pixel(input int m);
    int h, v;
    h = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1280, 4095)) : int'($urandom_range(0, 1279));
    v = ($urandom_range(0, 15) == 0) ? int'($urandom_range(720, 4095)) : int'($urandom_range(0, 719));
    if (h == 1279 && v == 719) v = 0;
    step(h, v, ($urandom_range(0, 4) != 0), 1'b0, m);
  endtask

  initial begin
    bus.hcount   = '0;
    bus.vcount   = '0;
    bus.de       = 1'b0;
    bus.mode_req = '0;
    rst          = 1'b1;
    @(negedge clk);

    // Reset state
    step(0, 0, 1'b1, 1'b1, 0);
    step(0, 0, 1'b0, 1'b1, 0);
    check_box();

    // Mode 0 border, fill, blanking
    step(0, 0, 1'b1, 1'b0, 0);
    step(100, 100, 1'b1, 1'b0, 0);
    step(100, 100, 1'b0, 1'b0, 0);
    step(1272, 300, 1'b1, 1'b0, 0);
    step(1271, 711, 1'b1, 1'b0, 0);

    // Mid-frame mode request is held off until frame end
    step(640, 360, 1'b1, 1'b0, 2);
    step(641, 360, 1'b1, 1'b0, 2);
    frame_end(2);
    step(32, 0, 1'b1, 1'b0, 2);
    step(32, 32, 1'b1, 1'b0, 2);
    check_box();

    // Colour bars, including the bar edges and remainder columns
    frame_end(1);
    for (int y = 0; y < 3; y++) begin
      int yy;
      yy = int'($urandom_range(0, 719));
      step(0, yy, 1'b1, 1'b0, 1);
      step(159, yy, 1'b1, 1'b0, 1);
      step(160, yy, 1'b1, 1'b0, 1);
      step(1119, yy, 1'b1, 1'b0, 1);
      step(1120, yy, 1'b1, 1'b0, 1);
      step(1279, yy, 1'b1, 1'b0, 1);
    end

    // Mode 3 right after reset: box at (4,4) after one frame end
    step(10, 10, 1'b1, 1'b1, 3);
    frame_end(3);
    check_box();
    step(4, 4, 1'b1, 1'b0, 3);
    step(3, 4, 1'b1, 1'b0, 3);
    step(68, 4, 1'b1, 1'b0, 3);
    step(67, 67, 1'b1, 1'b0, 3);

    // Long run: clamp and reverse on both axes
    for (int i = 2; i <= 305; i++) begin
      frame_end(3);
      check_box();
      if (i % 16 == 0) begin
        int bx, by;
        bx = tri_pos(nf, 1216);
        by = tri_pos(nf, 656);
        step(bx, by, 1'b1, 1'b0, 3);
        step(bx + 63, by + 63, 1'b1, 1'b0, 3);
        step(bx + 64, by, 1'b1, 1'b0, 3);
        random_pixel(3);
      end
    end

    // Randomised pixels and mode requests across all modes
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) frame_end(int'($urandom_range(0, 3)));
      else random_pixel(int'($urandom_range(0, 3)));
    end

    // Reset mid-frame in mode 3 after 50 frames
    step(0, 0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 50; i++) begin
      frame_end(3);
      if (i % 10 == 0) random_pixel(3);
    end
    check_box();
    step(500, 300, 1'b1, 1'b1, 3);
    check_box();
    step(501, 300, 1'b1, 1'b0, 3);
    frame_end(3);
    check_box();
    step(4, 4, 1'b1, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
